// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: special-value constants, divider FSM states and operand classes.
// Used by fp32_div and fp32_classify, and reusable by the multiplier.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam int          FP32_EXP_BIAS = 127;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    DIVIDE,
    NORM,
    FINISH
  } div_state_e;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

endpackage

// File: rtl/fp32_classify.sv
// Combinational fp32 operand classifier. Denormals are reported as ZERO,
// so they are flushed to zero downstream.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] x,
  output fp_class_e   cls
);

  always_comb begin
    if (x[30:23] == FP32_EXP_MAX) begin
      cls = (x[22:0] != 23'd0) ? NAN : INF;
    end else if (x[30:23] == 8'd0) begin
      cls = ZERO;
    end else begin
      cls = NORMAL;
    end
  end

endmodule

// File: rtl/fp32_div.sv
// Sequential fp32 divider using radix-2 restoring mantissa division, one quotient bit per cycle.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp32_div
  import fp32_pkg::*;
#(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        div_by_zero
);

  div_state_e  state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [24:0] rem_q, rem_d;
  logic [25:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [31:0] quotient_q, quotient_d;

  fp_class_e a_cls, b_cls;

  fp32_classify u_cls_a (.x(a_q), .cls(a_cls));
  fp32_classify u_cls_b (.x(b_q), .cls(b_cls));

  logic        sign;
  logic        is_special;
  logic [31:0] spec_res;
  logic        spec_dbz;

  assign sign       = a_q[31] ^ b_q[31];
  assign is_special = (a_cls != NORMAL) || (b_cls != NORMAL);

  // Ordered so that invalid operations win over infinities, and an infinite dividend over a zero divisor.
  always_comb begin
    spec_res = {sign, 31'd0};
    spec_dbz = 1'b0;
    if (a_cls == NAN || b_cls == NAN) begin
      spec_res = FP32_QNAN;
    end else if ((a_cls == INF && b_cls == INF) || (a_cls == ZERO && b_cls == ZERO)) begin
      spec_res = FP32_QNAN;
    end else if (a_cls == INF) begin
      spec_res = {sign, FP32_EXP_MAX, 23'd0};
    end else if (b_cls == ZERO) begin
      spec_res = {sign, FP32_EXP_MAX, 23'd0};
      spec_dbz = 1'b1;
    end
  end

  // The remainder is kept pre-shifted, so the final register holds 2*R; only its zero-ness matters.
  logic [24:0] mb_ext;
  logic [23:0] trial;
  logic        ge;
  logic [24:0] rem_next;

  assign mb_ext   = {2'b01, b_q[22:0]};
  assign ge       = rem_q >= mb_ext;
  assign trial    = rem_q[23:0] - mb_ext[23:0];
  assign rem_next = ge ? {trial, 1'b0} : {rem_q[23:0], 1'b0};

  logic signed [9:0] exp_diff, e_pre, e_fin;
  logic [22:0]       frac, frac_fin;
  logic              guard, sticky;
  logic [31:0]       norm_res;

  always_comb begin
    exp_diff = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]});
    if (quo_q[25]) begin
      frac   = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != 25'd0);
      e_pre  = exp_diff + $signed(10'(FP32_EXP_BIAS));
    end else begin
      frac   = quo_q[23:1];
      guard  = quo_q[0];
      sticky = rem_q != 25'd0;
      e_pre  = exp_diff + $signed(10'(FP32_EXP_BIAS - 1));
    end
  end

`ifdef FP32_DIV_ROUND_EN
  logic [23:0] mant_rnd;

  always_comb begin
    mant_rnd = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    frac_fin = mant_rnd[22:0];
    e_fin    = e_pre + $signed({9'd0, mant_rnd[23]});
  end
`else
  logic round_bits_unused;

  assign round_bits_unused = guard ^ sticky;
  assign frac_fin          = frac;
  assign e_fin             = e_pre;
`endif

  always_comb begin
    if (e_fin >= 10'sd255) begin
      norm_res = {sign, FP32_EXP_MAX, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      norm_res = {sign, 31'd0};
    end else begin
      norm_res = {sign, e_fin[7:0], frac_fin};
    end
  end

  // FINISH is the done cycle and accepts a new start exactly like IDLE.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    quotient_d = quotient_q;
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          rem_d   = {2'b01, a[22:0]};
          quo_d   = 26'd0;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (is_special) begin
          state_d = SPECIAL;
        end else begin
          rem_d = rem_next;
          quo_d = {quo_q[24:0], ge};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            state_d = NORM;
          end
        end
      end
      SPECIAL: begin
        quotient_d = spec_res;
        dbz_d      = spec_dbz;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = FINISH;
      end
      NORM: begin
        quotient_d = norm_res;
        dbz_d      = 1'b0;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rem_q      <= 25'd0;
      quo_q      <= 26'd0;
      cnt_q      <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      quotient_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      quotient_q <= quotient_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp32_div.sv
// Directed self-checking bench for fp32_div: results, latency, special values and control.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp32_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient;

  int check_count = 0;
  int pass_count  = 0;

  fp32_div dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Caller must be at a falling edge; returns at the falling edge where done is seen.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib,
                               output logic [31:0] q, output logic dbz,
                               output int lat, output bit busy_ok);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    q   = quotient;
    dbz = div_by_zero;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (done !== 1'b0) $display("[TB] FAIL reset done: got %b expected 0", done);
    else pass_count++;
    check_count++;
    if (quotient !== 32'd0) $display("[TB] FAIL reset quotient: got %h expected 00000000", quotient);
    else pass_count++;
    check_count++;
    if (div_by_zero !== 1'b0) $display("[TB] FAIL reset div_by_zero: got %b expected 0", div_by_zero);
    else pass_count++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    logic [31:0] q;
    logic        dbz;
    int          lat;
    bit          bok;
    applyStimulus(32'h40C00000, 32'h40000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h40400000) $display("[TB] FAIL div_6_2 quotient: got %h expected 40400000", q);
    else pass_count++;
    check_count++;
    if (lat !== 27) $display("[TB] FAIL div_6_2 latency: got %0d expected 27", lat);
    else pass_count++;
    check_count++;
    if (bok !== 1'b1) $display("[TB] FAIL div_6_2 busy profile: got %b expected 1", bok);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (done !== 1'b0 || quotient !== 32'h40400000)
      $display("[TB] FAIL done_pulse_hold: got done=%b q=%h expected done=0 q=40400000", done, quotient);
    else pass_count++;
    applyStimulus(32'hC0C00000, 32'h40000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'hC0400000) $display("[TB] FAIL div_neg6_2 quotient: got %h expected C0400000", q);
    else pass_count++;
  endtask

  task automatic test_rounding();
    logic [31:0] q;
    logic [31:0] expected;
    logic        dbz;
    int          lat;
    bit          bok;
`ifdef FP32_DIV_ROUND_EN
    expected = 32'h3EAAAAAB;
`else
    expected = 32'h3EAAAAAA;
`endif
    applyStimulus(32'h3F800000, 32'h40400000, q, dbz, lat, bok);
    check_count++;
    if (q !== expected) $display("[TB] FAIL div_1_3 quotient: got %h expected %h", q, expected);
    else pass_count++;
    check_count++;
    if (lat !== 27) $display("[TB] FAIL div_1_3 latency: got %0d expected 27", lat);
    else pass_count++;
  endtask

  task automatic test_div_by_zero();
    logic [31:0] q;
    logic        dbz;
    int          lat;
    bit          bok;
    applyStimulus(32'h3F800000, 32'h00000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7F800000) $display("[TB] FAIL dbz_pos quotient: got %h expected 7F800000", q);
    else pass_count++;
    check_count++;
    if (dbz !== 1'b1) $display("[TB] FAIL dbz_pos flag: got %b expected 1", dbz);
    else pass_count++;
    check_count++;
    if (lat !== 2) $display("[TB] FAIL dbz_pos latency: got %0d expected 2", lat);
    else pass_count++;
    applyStimulus(32'hBF800000, 32'h00000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'hFF800000 || dbz !== 1'b1)
      $display("[TB] FAIL dbz_neg: got q=%h dbz=%b expected q=FF800000 dbz=1", q, dbz);
    else pass_count++;
    applyStimulus(32'h7F800000, 32'h00000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7F800000 || dbz !== 1'b0)
      $display("[TB] FAIL inf_over_zero: got q=%h dbz=%b expected q=7F800000 dbz=0", q, dbz);
    else pass_count++;
  endtask

  task automatic test_invalid();
    logic [31:0] q;
    logic        dbz;
    int          lat;
    bit          bok;
    applyStimulus(32'h00000000, 32'h00000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7FC00000 || dbz !== 1'b0)
      $display("[TB] FAIL zero_over_zero: got q=%h dbz=%b expected q=7FC00000 dbz=0", q, dbz);
    else pass_count++;
    check_count++;
    if (lat !== 2) $display("[TB] FAIL zero_over_zero latency: got %0d expected 2", lat);
    else pass_count++;
    applyStimulus(32'h80000000, 32'h00000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7FC00000) $display("[TB] FAIL negzero_over_zero: got %h expected 7FC00000", q);
    else pass_count++;
    applyStimulus(32'h7F800000, 32'hFF800000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7FC00000) $display("[TB] FAIL inf_over_inf: got %h expected 7FC00000", q);
    else pass_count++;
    applyStimulus(32'h7FC00001, 32'h3F800000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7FC00000) $display("[TB] FAIL nan_operand: got %h expected 7FC00000", q);
    else pass_count++;
  endtask

  task automatic test_zero_result();
    logic [31:0] q;
    logic        dbz;
    int          lat;
    bit          bok;
    applyStimulus(32'h80000000, 32'h40000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h80000000) $display("[TB] FAIL negzero_over_two: got %h expected 80000000", q);
    else pass_count++;
    applyStimulus(32'h40000000, 32'hFF800000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h80000000) $display("[TB] FAIL two_over_neginf: got %h expected 80000000", q);
    else pass_count++;
    applyStimulus(32'h00400000, 32'h3F800000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h00000000 || lat !== 2)
      $display("[TB] FAIL denormal_flush: got q=%h lat=%0d expected q=00000000 lat=2", q, lat);
    else pass_count++;
  endtask

  task automatic test_range();
    logic [31:0] q;
    logic        dbz;
    int          lat;
    bit          bok;
    applyStimulus(32'h7F000000, 32'h3E800000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h7F800000 || dbz !== 1'b0)
      $display("[TB] FAIL overflow: got q=%h dbz=%b expected q=7F800000 dbz=0", q, dbz);
    else pass_count++;
    check_count++;
    if (lat !== 27) $display("[TB] FAIL overflow latency: got %0d expected 27", lat);
    else pass_count++;
    applyStimulus(32'h00800000, 32'h40000000, q, dbz, lat, bok);
    check_count++;
    if (q !== 32'h00000000) $display("[TB] FAIL underflow: got %h expected 00000000", q);
    else pass_count++;
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra_done;
    @(negedge clk);
    a     = 32'h40C00000;
    b     = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    repeat (4) @(negedge clk);
    lat   = 4;
    a     = 32'h3F800000;
    b     = 32'h00000000;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_count++;
    if (quotient !== 32'h40400000 || div_by_zero !== 1'b0)
      $display("[TB] FAIL ignore_start result: got q=%h dbz=%b expected q=40400000 dbz=0", quotient, div_by_zero);
    else pass_count++;
    check_count++;
    if (lat !== 27) $display("[TB] FAIL ignore_start latency: got %0d expected 27", lat);
    else pass_count++;
    extra_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    check_count++;
    if (extra_done !== 0) $display("[TB] FAIL ignore_start extra done: got %0d expected 0", extra_done);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_count++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || div_by_zero !== 1'b0)
      $display("[TB] FAIL reset_mid outputs: got busy=%b done=%b q=%h dbz=%b expected all 0",
               busy, done, quotient, div_by_zero);
    else pass_count++;
    rst       = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check_count++;
    if (seen_done !== 0) $display("[TB] FAIL reset_mid activity: got %0d cycles expected 0", seen_done);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q1, q2;
    logic        dbz;
    int          lat1, lat2;
    bit          bok;
    applyStimulus(32'h40C00000, 32'h40000000, q1, dbz, lat1, bok);
    applyStimulus(32'h3F800000, 32'h3F800000, q2, dbz, lat2, bok);
    check_count++;
    if (q1 !== 32'h40400000) $display("[TB] FAIL b2b first: got %h expected 40400000", q1);
    else pass_count++;
    check_count++;
    if (q2 !== 32'h3F800000) $display("[TB] FAIL b2b second: got %h expected 3F800000", q2);
    else pass_count++;
    check_count++;
    if (lat2 !== 27 || bok !== 1'b1)
      $display("[TB] FAIL b2b timing: got lat=%0d busy_ok=%b expected lat=27 busy_ok=1", lat2, bok);
    else pass_count++;
  endtask

  initial begin
    $display("[TB] starting fp32_div bench");
    test_reset();
    test_normal();
    test_rounding();
    test_div_by_zero();
    test_invalid();
    test_zero_result();
    test_range();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
